// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the 5-stage pipeline. This block owns the
// program counter and drives a combinational-read instruction memory: the
// word for iaddr comes back on instr_in in the same cycle. Fetched words are
// pushed, together with their PC, into a small circular queue. The head of
// the queue is handed to decode over a valid/ready handshake.
//
// A redirect from EX (taken branch, jal or jalr) flushes every queued fetch
// and reloads the PC. If the redirect target is not word-aligned, the PC is
// left unchanged and a sticky misalign_err flag is raised. While that flag is
// set, fetching stops. It stays stopped until an aligned redirect or a reset.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   QDEPTH     fetch-queue entries (power of 2, >= 2)
//   NOP_INSTR  value shown on id_instr while the queue is empty
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous reset, active-low
//   redirect_en   in   1   EX redirect request
//   redirect_pc   in   32  redirect target
//   iaddr         out  32  byte address to instruction memory (= PC register)
//   imem_cs_n     out  1   instruction memory select, active-low
//   instr_in      in   32  instruction word for iaddr, same cycle
//   id_valid      out  1   queue head holds a valid instruction
//   id_ready      in   1   decode accepts the head this cycle
//   id_instr      out  32  head instruction (NOP_INSTR when empty)
//   id_pc         out  32  PC of head instruction
//   id_pc_plus4   out  32  id_pc + 4 (mod 2^32)
//   misalign_err  out  1   sticky: redirect target was not word-aligned
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] iaddr,
  output logic        imem_cs_n,
  input  logic [31:0] instr_in,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misalign_err
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = $clog2(QDEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Control state (reset)
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic             r_misalign;

  // Queue storage (data only, never reset)
  logic [31:0] r_instr_q [QDEPTH];
  logic [31:0] r_pc_q    [QDEPTH];

  logic w_valid;
  logic w_pop;
  logic w_fetch_en;
  logic w_not_full;
  logic w_target_aligned;

  assign w_valid          = (r_count != '0);
  assign w_pop            = w_valid & id_ready;
  assign w_not_full       = (r_count < CNT_FULL);
  assign w_target_aligned = (redirect_pc[1:0] == 2'b00);

  // A full queue can still take a new word in the same cycle that its head
  // leaves. Fetching also stops while reset, a redirect or a misalignment
  // error is active. This keeps iaddr steady and the memory deselected.
  assign w_fetch_en = rst & ~r_misalign & ~redirect_en & (w_not_full | w_pop);

  assign iaddr     = r_pc;
  assign imem_cs_n = ~w_fetch_en;

  // The head comes only from storage, never from instr_in. A word fetched in
  // cycle N therefore shows up on id_* in cycle N+1. An empty queue shows a
  // NOP with PC 0, so nothing undefined reaches decode.
  assign id_valid     = w_valid;
  assign id_instr     = w_valid ? r_instr_q[r_rd_ptr] : NOP_INSTR;
  assign id_pc        = w_valid ? r_pc_q[r_rd_ptr]    : 32'h0000_0000;
  assign id_pc_plus4  = id_pc + 32'd4;
  assign misalign_err = r_misalign;

  // ---- fetch -> queue boundary: control registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_misalign <= 1'b0;
    end else if (redirect_en) begin
      // A redirect flushes the queue. The head is dropped even if decode is
      // ready this cycle, so no pop is counted.
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      if (w_target_aligned) begin
        r_pc       <= redirect_pc;
        r_misalign <= 1'b0;
      end else begin
        r_misalign <= 1'b1;
      end
    end else begin
      if (w_fetch_en) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_fetch_en, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- fetch -> queue boundary: entry storage ----
  always_ff @(posedge clk) begin
    if (w_fetch_en) begin
      r_instr_q[r_wr_ptr] <= instr_in;
      r_pc_q[r_wr_ptr]    <= r_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int          QD  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Instruction memory contents: an odd multiplier makes every address map
  // to a distinct word.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst, redirect_en, id_ready;
  logic [31:0] redirect_pc, iaddr, instr_in, id_instr, id_pc, id_pc_plus4;
  logic        imem_cs_n, id_valid, misalign_err;

  assign instr_in = memword(iaddr);

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QD), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .iaddr(iaddr), .imem_cs_n(imem_cs_n), .instr_in(instr_in),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .misalign_err(misalign_err)
  );

  // Second DUT for PC wrap-around (RESET_PC near top of address space)
  logic        rst5, redirect_en5, id_ready5;
  logic [31:0] redirect_pc5, iaddr5, instr_in5, id_instr5, id_pc5, id_pc_plus45;
  logic        imem_cs_n5, id_valid5, misalign_err5;

  assign instr_in5 = memword(iaddr5);

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD), .NOP_INSTR(NOP)) dut5 (
    .clk(clk), .rst(rst5), .redirect_en(redirect_en5), .redirect_pc(redirect_pc5),
    .iaddr(iaddr5), .imem_cs_n(imem_cs_n5), .instr_in(instr_in5),
    .id_valid(id_valid5), .id_ready(id_ready5), .id_instr(id_instr5),
    .id_pc(id_pc5), .id_pc_plus4(id_pc_plus45), .misalign_err(misalign_err5)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          chk;
    bit          rst_n;
    bit          red;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_cs_n;
    logic [31:0] e_iaddr;
    bit          e_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit c, input bit r, input bit red, input logic [31:0] rpc,
                     input bit rdy, input bit ev, input logic [31:0] epc, input bit ecs,
                     input logic [31:0] eia, input bit em);
    vec_t v;
    v.chk = c; v.rst_n = r; v.red = red; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_cs_n = ecs; v.e_iaddr = eia; v.e_mis = em;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_mis;

  task automatic rstep(input bit r, input bit red, input logic [31:0] rpc, input bit rdy);
    bit   ev, pop, fe;
    ent_t e;
    rst = r; redirect_en = red; redirect_pc = rpc; id_ready = rdy;
    @(negedge clk);
    ev  = (mq.size() > 0);
    pop = ev && rdy;
    fe  = r && !m_mis && !red && ((mq.size() < QD) || pop);
    chk("rnd_valid", {31'b0, id_valid}, {31'b0, ev});
    if (ev) begin
      chk("rnd_instr", id_instr, mq[0].instr);
      chk("rnd_pc", id_pc, mq[0].pc);
      chk("rnd_pc4", id_pc_plus4, mq[0].pc + 32'd4);
    end else begin
      chk("rnd_nop", id_instr, NOP);
    end
    chk("rnd_cs_n", {31'b0, imem_cs_n}, {31'b0, !fe});
    chk("rnd_iaddr", iaddr, m_pc);
    chk("rnd_mis", {31'b0, misalign_err}, {31'b0, m_mis});
    if (!r) begin
      mq.delete(); m_pc = 32'h0; m_mis = 1'b0;
    end else if (red) begin
      mq.delete();
      if (rpc[1:0] == 2'b00) begin
        m_pc = rpc; m_mis = 1'b0;
      end else begin
        m_mis = 1'b1;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (fe) begin
        e.instr = memword(m_pc); e.pc = m_pc;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] wrap_pc [4];
    logic [31:0] wrap_ia [4];
    logic [31:0] rpc;

    rst = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    rst5 = 1'b0; redirect_en5 = 1'b0; redirect_pc5 = 32'h0; id_ready5 = 1'b1;

    // Row fields: chk rst red rpc rdy | valid pc cs_n iaddr mis
    // T1: streaming with ready high
    add(1,1,0,0,1, 0,32'h000,0,32'h000,0);
    add(1,1,0,0,1, 1,32'h000,0,32'h004,0);
    add(1,1,0,0,1, 1,32'h004,0,32'h008,0);
    add(1,1,0,0,1, 1,32'h008,0,32'h00C,0);
    // T2: stall for 5 cycles, then drain in order
    add(0,0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0, 0,32'h000,0,32'h000,0);
    add(1,1,0,0,0, 1,32'h000,0,32'h004,0);
    add(1,1,0,0,0, 1,32'h000,1,32'h008,0);
    add(1,1,0,0,0, 1,32'h000,1,32'h008,0);
    add(1,1,0,0,0, 1,32'h000,1,32'h008,0);
    add(1,1,0,0,1, 1,32'h000,0,32'h008,0);
    add(1,1,0,0,1, 1,32'h004,0,32'h00C,0);
    add(1,1,0,0,1, 1,32'h008,0,32'h010,0);
    add(1,1,0,0,1, 1,32'h00C,0,32'h014,0);
    // T3: fill queue (0,4), redirect to 0x100 with ready high
    add(0,0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0, 0,32'h000,0,32'h000,0);
    add(1,1,0,0,0, 1,32'h000,0,32'h004,0);
    add(1,1,1,32'h100,1, 1,32'h000,1,32'h008,0);
    add(1,1,0,0,1, 0,32'h000,0,32'h100,0);
    add(1,1,0,0,1, 1,32'h100,0,32'h104,0);
    // T4: misaligned redirect, 10 idle cycles, aligned redirect recovers
    add(1,1,1,32'h102,1, 1,32'h104,1,32'h108,0);
    for (int i = 0; i < 10; i++) add(1,1,0,0,1, 0,32'h000,1,32'h108,1);
    add(1,1,1,32'h200,1, 0,32'h000,1,32'h108,1);
    add(1,1,0,0,1, 0,32'h000,0,32'h200,0);
    add(1,1,0,0,0, 1,32'h200,0,32'h204,0);
    add(1,1,0,0,0, 1,32'h200,1,32'h208,0);
    // T6: reset with full queue and redirect asserted together
    add(0,0,1,32'h300,1, 0,0,0,0,0);
    add(1,1,1,32'h003,0, 0,32'h000,1,32'h000,0);
    add(1,1,0,0,1, 0,32'h000,1,32'h000,1);
    add(0,0,0,0,1, 0,0,0,0,0);
    add(1,1,0,0,1, 0,32'h000,0,32'h000,0);

    // Initial reset and reset-state check
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h4);
    chk("rst_mis", {31'b0, misalign_err}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_cs_n", {31'b0, imem_cs_n}, 32'h1);
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      rst = tbl[k].rst_n; redirect_en = tbl[k].red;
      redirect_pc = tbl[k].rpc; id_ready = tbl[k].rdy;
      @(negedge clk);
      if (tbl[k].chk) begin
        chk($sformatf("tbl%0d_valid", k), {31'b0, id_valid}, {31'b0, tbl[k].e_valid});
        chk($sformatf("tbl%0d_instr", k), id_instr,
            tbl[k].e_valid ? memword(tbl[k].e_pc) : NOP);
        if (tbl[k].e_valid) begin
          chk($sformatf("tbl%0d_pc", k), id_pc, tbl[k].e_pc);
          chk($sformatf("tbl%0d_pc4", k), id_pc_plus4, tbl[k].e_pc + 32'd4);
        end
        chk($sformatf("tbl%0d_cs_n", k), {31'b0, imem_cs_n}, {31'b0, tbl[k].e_cs_n});
        chk($sformatf("tbl%0d_iaddr", k), iaddr, tbl[k].e_iaddr);
        chk($sformatf("tbl%0d_mis", k), {31'b0, misalign_err}, {31'b0, tbl[k].e_mis});
      end
      @(posedge clk); #1;
    end

    // T5: PC wrap-around on the second instance
    wrap_pc[0] = 32'h0;         wrap_ia[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFF8; wrap_ia[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'hFFFF_FFFC; wrap_ia[2] = 32'h0000_0000;
    wrap_pc[3] = 32'h0000_0000; wrap_ia[3] = 32'h0000_0004;
    rst5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wrap%0d_valid", i), {31'b0, id_valid5}, (i == 0) ? 32'h0 : 32'h1);
      chk($sformatf("wrap%0d_iaddr", i), iaddr5, wrap_ia[i]);
      if (i != 0) begin
        chk($sformatf("wrap%0d_pc", i), id_pc5, wrap_pc[i]);
        chk($sformatf("wrap%0d_pc4", i), id_pc_plus45, wrap_pc[i] + 32'd4);
        chk($sformatf("wrap%0d_instr", i), id_instr5, memword(wrap_pc[i]));
      end
      @(posedge clk); #1;
    end

    // Randomized run against the reference model
    rst = 1'b0; redirect_en = 1'b0; id_ready = 1'b0;
    @(posedge clk); #1;
    mq.delete(); m_pc = 32'h0; m_mis = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF4;
      if ($urandom_range(0, 4) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      rstep($urandom_range(0, 99) != 0, $urandom_range(0, 15) == 0, rpc,
            $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
